// File: rtl/rock_ramp_scheduler.sv
// Ramps amp/freq setpoints one level per tick toward latched targets, freq before amp-up,
// with forced ramp-down while heart rate is bad. Optional: HR_TIMEOUT_WATCHDOG_EN.
module rock_ramp_scheduler #(
    parameter int MAX_LEVEL     = 7,
    parameter int DWELL_TICKS   = 4,
    parameter int HR_MIN        = 40,
    parameter int HR_MAX        = 180,
    parameter int RECOVER_TICKS = 8,
    parameter int HR_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       req_valid,
    input  logic [2:0] amp_req,
    input  logic [2:0] freq_req,
    input  logic       hr_valid,
    input  logic [7:0] hartslag,
    output logic [2:0] amp,
    output logic [2:0] freq,
    output logic       busy,
    output logic       fault
);
    localparam int DW = $clog2(DWELL_TICKS + 1);
    localparam int RW = $clog2(RECOVER_TICKS + 1);
    localparam logic [2:0]    MAXL  = 3'(MAX_LEVEL);
    localparam logic [7:0]    HRLO  = 8'(HR_MIN);
    localparam logic [7:0]    HRHI  = 8'(HR_MAX);
    localparam logic [DW-1:0] DWELL = DW'(DWELL_TICKS);
    localparam logic [RW-1:0] RECOV = RW'(RECOVER_TICKS);

    typedef enum logic [1:0] {IDLE, STEP, DWELL_S, SAFE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    tgt_amp, tgt_freq;
    logic [2:0]    amp_step, freq_step;
    logic [DW-1:0] dwell_cnt;
    logic [RW-1:0] rec_cnt;
    logic          hr_ok, hr_in_range, at_tgt;

    assign hr_in_range = (hartslag >= HRLO) && (hartslag <= HRHI);
    assign at_tgt      = (amp == tgt_amp) && (freq == tgt_freq);

    // Amplitude may only rise once frequency has settled.
    always_comb begin
        amp_step  = amp;
        freq_step = freq;
        if (amp > tgt_amp)        amp_step  = amp - 3'd1;
        else if (freq > tgt_freq) freq_step = freq - 3'd1;
        else if (freq < tgt_freq) freq_step = freq + 3'd1;
        else if (amp < tgt_amp)   amp_step  = amp + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!hr_ok) state_nxt = SAFE;
                     else if (!at_tgt) state_nxt = STEP;
            STEP:    if (!hr_ok) state_nxt = SAFE;
                     else if (tick) state_nxt = DWELL_S;
            DWELL_S: if (!hr_ok) state_nxt = SAFE;
                     else if (tick && dwell_cnt <= DW'(1)) state_nxt = at_tgt ? IDLE : STEP;
            SAFE:    if (amp == 3'd0 && freq == 3'd0 && rec_cnt == RECOV) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        fault = (state == SAFE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_amp  <= 3'd0;
            tgt_freq <= 3'd0;
        end else if (req_valid) begin
            tgt_amp  <= (amp_req  > MAXL) ? MAXL : amp_req;
            tgt_freq <= (freq_req > MAXL) ? MAXL : freq_req;
        end
    end

`ifdef HR_TIMEOUT_WATCHDOG_EN
    localparam int WW = $clog2(HR_TIMEOUT + 1);
    localparam logic [WW-1:0] HRTO = WW'(HR_TIMEOUT);
    logic [WW-1:0] wd_cnt;

    // Silence from the sensor is treated as a bad reading once the count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            hr_ok  <= 1'b1;
            wd_cnt <= '0;
        end else if (hr_valid) begin
            hr_ok  <= hr_in_range;
            wd_cnt <= '0;
        end else if (tick && wd_cnt != HRTO) begin
            wd_cnt <= wd_cnt + WW'(1);
            if (wd_cnt + WW'(1) == HRTO) hr_ok <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset)         hr_ok <= 1'b1;
        else if (hr_valid) hr_ok <= hr_in_range;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            amp       <= 3'd0;
            freq      <= 3'd0;
            dwell_cnt <= '0;
            rec_cnt   <= '0;
        end else begin
            case (state)
                STEP: if (hr_ok && tick) begin
                    amp       <= amp_step;
                    freq      <= freq_step;
                    dwell_cnt <= DWELL;
                end
                DWELL_S: if (hr_ok && tick) dwell_cnt <= dwell_cnt - DW'(1);
                SAFE: begin
                    if (tick) begin
                        if (amp != 3'd0)       amp  <= amp - 3'd1;
                        else if (freq != 3'd0) freq <= freq - 3'd1;
                    end
                    if (state_nxt == IDLE || !hr_ok) rec_cnt <= '0;
                    else if (tick && rec_cnt != RECOV) rec_cnt <= rec_cnt + RW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
